hood_mode_fsm: RTL and testbench
================================

HOOD_MODE_FSM -- requirements
Module: hood_mode_fsm

Interface
REQ-001 Parameter NUM_LVL, default 3, number of smoking levels, legal range 2..7.
REQ-002 Parameter TICKS_PER_SEC, default 100, clk_100Hz cycles per second, legal range 2..1023.
REQ-003 Parameter CLEAN_SEC, default 180, cleaning duration in seconds, legal range 1..65535.
REQ-004 Parameter TURBO_SEC, default 60, top-level (turbo) run time in seconds, legal range 1..65535.
REQ-005 clk_100Hz  in  1  sole clock; all flops rise-edge triggered.
REQ-006 reset  in  1  asynchronous, active-high.
REQ-007 power_on  in  1  level; high = hood powered.
REQ-008 menu  in  1  raw menu button, undebounced.
REQ-009 mode_sel  in  NUM_LVL+1  one-hot request; bit i-1 = level i (1..NUM_LVL), bit NUM_LVL = cleaning.
REQ-010 state  out  2  OFF=0, STANDBY=1, SMOKING=2, CLEANING=3.
REQ-011 lvl  out  LW=$clog2(NUM_LVL+1)  active level; 0 unless state=SMOKING.
REQ-012 remaining_sec  out  16  countdown in CLEANING or turbo; 0 otherwise.
REQ-013 done_pulse  out  1  one-cycle high when a timed mode expires.

Function
REQ-014 Debounce: sample register prev<=menu every edge; stable<=menu only when menu==prev.
REQ-015 Menu event = edge at which stable changes 1->0; the event is consumed in that same edge, so the action is visible 2 edges after menu falls.
REQ-016 power_on low: next edge forces OFF, lvl=0, remaining_sec=0, tick counter=0; overrides all events.
REQ-017 OFF with power_on high -> STANDBY next edge; any event on that edge is ignored.
REQ-018 STANDBY + event + mode_sel exactly one-hot -> SMOKING at level i, or CLEANING; zero or multi-hot mode_sel -> event ignored, stay STANDBY.
REQ-019 SMOKING, lvl<NUM_LVL, event -> STANDBY; mode_sel ignored.
REQ-020 SMOKING, lvl=NUM_LVL (turbo): events ignored; timed by TURBO_SEC.
REQ-021 CLEANING: events ignored; timed by CLEAN_SEC.
REQ-022 On entry to a timed mode: remaining_sec<=duration, tick counter<=0.
REQ-023 Tick counter counts 0..TICKS_PER_SEC-1 and wraps; on wrap remaining_sec decrements.
REQ-024 On the wrap edge with remaining_sec==1: remaining_sec<=0, done_pulse=1 for that cycle, exit per REQ-025; a timed mode lasts exactly duration*TICKS_PER_SEC cycles.
REQ-025 Expiry exit: CLEANING -> STANDBY; turbo -> per REQ-029/030.
REQ-026 Expiry coincident with power_on low: OFF wins; done_pulse stays 0.
REQ-027 remaining_sec never underflows; tick counter and remaining_sec are held at 0 outside timed modes.

Reset
REQ-028 reset high: state=OFF, lvl=0, remaining_sec=0, done_pulse=0, prev=0, stable=0, tick counter=0, immediately and asynchronously; release mid-operation restarts from OFF.

Configuration
REQ-029 Macro HOOD_TURBO_DOWNSHIFT_EN defined: turbo expiry -> SMOKING at lvl=NUM_LVL-1, remaining_sec=0, untimed.
REQ-030 Macro undefined: turbo expiry -> STANDBY, lvl=0.

Structure
REQ-031 Package hood_pkg holds the 2-bit state encodings and the remaining_sec width constant (16).
REQ-032 Debounce and event detection live in sub-module menu_debounce (clk_100Hz, reset, menu -> release_evt).

Verification (TICKS_PER_SEC=4, CLEAN_SEC=3, TURBO_SEC=2, NUM_LVL=3)
REQ-033 reset, power_on=1 -> STANDBY after 1 edge; menu high 5 cycles with mode_sel=0001 -> state=2, lvl=1 at 2nd edge after menu falls; second press -> STANDBY.
REQ-034 STANDBY, mode_sel=1000, press -> CLEANING, remaining_sec=3; after exactly 12 edges: STANDBY, done_pulse high one cycle.
REQ-035 mode_sel=0011 or 0000, press -> stays STANDBY; menu glitch of 1 cycle -> no event.
REQ-036 Turbo (0100), press during run ignored; after 8 edges: STANDBY, or lvl=2 untimed with HOOD_TURBO_DOWNSHIFT_EN.
REQ-037 power_on dropped mid-CLEANING -> OFF next edge, remaining_sec=0; reset asserted mid-turbo -> all outputs 0 immediately.

Source files
------------

// File: rtl/hood_pkg.sv
// Shared encodings for the range-hood mode controller.
package hood_pkg;

    localparam int unsigned REM_W = 16;

    localparam logic [1:0] ST_OFF      = 2'd0;
    localparam logic [1:0] ST_STANDBY  = 2'd1;
    localparam logic [1:0] ST_SMOKING  = 2'd2;
    localparam logic [1:0] ST_CLEANING = 2'd3;

endpackage

// File: rtl/menu_debounce.sv
// Menu button debouncer; release_evt marks the edge at which the debounced level falls.
module menu_debounce (
    input  logic clk_100Hz,
    input  logic reset,
    input  logic menu,
    output logic release_evt
);

    logic prev;
    logic stable;

    always_ff @(posedge clk_100Hz or posedge reset) begin
        if (reset) begin
            prev   <= 1'b0;
            stable <= 1'b0;
        end else begin
            prev <= menu;
            if (menu == prev)
                stable <= menu;
        end
    end

    // Combinational so the FSM consumes the event on the same edge stable drops.
    assign release_evt = stable && !menu && !prev;

endmodule

// File: rtl/hood_mode_fsm.sv
// Range-hood mode controller (OFF/STANDBY/SMOKING/CLEANING) with timed turbo and cleaning.
// Optional macro HOOD_TURBO_DOWNSHIFT_EN: turbo expiry drops to level NUM_LVL-1 instead of STANDBY.
module hood_mode_fsm
    import hood_pkg::*;
#(
    parameter  int NUM_LVL       = 3,
    parameter  int TICKS_PER_SEC = 100,
    parameter  int CLEAN_SEC     = 180,
    parameter  int TURBO_SEC     = 60,
    localparam int LW            = $clog2(NUM_LVL + 1)
) (
    input  logic               clk_100Hz,
    input  logic               reset,
    input  logic               power_on,
    input  logic               menu,
    input  logic [NUM_LVL:0]   mode_sel,
    output logic [1:0]         state,
    output logic [LW-1:0]      lvl,
    output logic [REM_W-1:0]   remaining_sec,
    output logic               done_pulse
);

    localparam int TW = $clog2(TICKS_PER_SEC);

    logic          release_evt;
    logic [TW-1:0] tick;
    logic          sel_valid;
    logic [LW-1:0] sel_lvl;
    logic          is_turbo;
    logic          wrap;

    menu_debounce u_debounce (
        .clk_100Hz   (clk_100Hz),
        .reset       (reset),
        .menu        (menu),
        .release_evt (release_evt)
    );

    always_comb begin
        sel_lvl = '0;
        for (int unsigned i = 0; i < NUM_LVL; i++)
            if (mode_sel[i])
                sel_lvl = LW'(i + 1);
    end

    assign sel_valid = (mode_sel != '0) && ((mode_sel & (mode_sel - 1'b1)) == '0);
    assign is_turbo  = (lvl == LW'(NUM_LVL));
    assign wrap      = (tick == TW'(TICKS_PER_SEC - 1));

    always_ff @(posedge clk_100Hz or posedge reset) begin
        if (reset) begin
            state         <= ST_OFF;
            lvl           <= '0;
            remaining_sec <= '0;
            tick          <= '0;
            done_pulse    <= 1'b0;
        end else begin
            done_pulse <= 1'b0;
            if (!power_on) begin
                state         <= ST_OFF;
                lvl           <= '0;
                remaining_sec <= '0;
                tick          <= '0;
            end else begin
                case (state)
                    ST_OFF: state <= ST_STANDBY;
                    ST_STANDBY: begin
                        if (release_evt && sel_valid) begin
                            tick <= '0;
                            if (mode_sel[NUM_LVL]) begin
                                state         <= ST_CLEANING;
                                remaining_sec <= REM_W'(CLEAN_SEC);
                            end else begin
                                state <= ST_SMOKING;
                                lvl   <= sel_lvl;
                                if (sel_lvl == LW'(NUM_LVL))
                                    remaining_sec <= REM_W'(TURBO_SEC);
                            end
                        end
                    end
                    default: begin
                        // Turbo and cleaning share the countdown; lower levels only react to the button.
                        if (state == ST_CLEANING || is_turbo) begin
                            if (wrap) begin
                                tick <= '0;
                                if (remaining_sec == REM_W'(1)) begin
                                    remaining_sec <= '0;
                                    done_pulse    <= 1'b1;
                                    if (state == ST_CLEANING) begin
                                        state <= ST_STANDBY;
                                    end else begin
`ifdef HOOD_TURBO_DOWNSHIFT_EN
                                        lvl   <= LW'(NUM_LVL - 1);
`else
                                        state <= ST_STANDBY;
                                        lvl   <= '0;
`endif
                                    end
                                end else if (remaining_sec != '0) begin
                                    remaining_sec <= remaining_sec - 1'b1;
                                end
                            end else begin
                                tick <= tick + 1'b1;
                            end
                        end else if (release_evt) begin
                            state <= ST_STANDBY;
                            lvl   <= '0;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hood_mode_fsm.sv
// Directed self-checking bench for hood_mode_fsm (4 ticks/s, 3 s clean, 2 s turbo, 3 levels).
module tb_hood_mode_fsm;

    logic        clk_100Hz = 1'b0;
    logic        reset     = 1'b1;
    logic        power_on  = 1'b0;
    logic        menu      = 1'b0;
    logic [3:0]  mode_sel  = 4'b0000;
    logic [1:0]  state;
    logic [1:0]  lvl;
    logic [15:0] remaining_sec;
    logic        done_pulse;

    int n_checks = 0;
    int n_fail   = 0;

    hood_mode_fsm #(
        .NUM_LVL       (3),
        .TICKS_PER_SEC (4),
        .CLEAN_SEC     (3),
        .TURBO_SEC     (2)
    ) dut (
        .clk_100Hz     (clk_100Hz),
        .reset         (reset),
        .power_on      (power_on),
        .menu          (menu),
        .mode_sel      (mode_sel),
        .state         (state),
        .lvl           (lvl),
        .remaining_sec (remaining_sec),
        .done_pulse    (done_pulse)
    );

    always #5 clk_100Hz = ~clk_100Hz;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_100Hz);
        #1;
    endtask

    // Hold menu 5 cycles, release; action lands on the 2nd edge after release.
    task automatic press();
        menu = 1'b1;
        step(5);
        menu = 1'b0;
        step(2);
    endtask

    initial begin
        step(2);
        check_val("rst_state", state, 0);
        check_val("rst_lvl", lvl, 0);
        check_val("rst_rem", remaining_sec, 0);
        check_val("rst_done", done_pulse, 0);

        reset    = 1'b0;
        power_on = 1'b1;
        step(1);
        check_val("off_to_standby", state, 1);

        mode_sel = 4'b0001;
        menu = 1'b1;
        step(5);
        menu = 1'b0;
        step(1);
        check_val("lvl1_not_yet", state, 1);
        step(1);
        check_val("lvl1_state", state, 2);
        check_val("lvl1_lvl", lvl, 1);
        check_val("lvl1_rem", remaining_sec, 0);
        press();
        check_val("lvl1_exit_state", state, 1);
        check_val("lvl1_exit_lvl", lvl, 0);

        mode_sel = 4'b1000;
        press();
        check_val("clean_state", state, 3);
        check_val("clean_rem", remaining_sec, 3);
        step(4);
        check_val("clean_rem_4", remaining_sec, 2);
        step(7);
        check_val("clean_state_11", state, 3);
        check_val("clean_rem_11", remaining_sec, 1);
        check_val("clean_done_11", done_pulse, 0);
        step(1);
        check_val("clean_exp_state", state, 1);
        check_val("clean_exp_done", done_pulse, 1);
        check_val("clean_exp_rem", remaining_sec, 0);
        step(1);
        check_val("clean_done_clear", done_pulse, 0);

        mode_sel = 4'b0011;
        press();
        check_val("multihot_ignored", state, 1);
        mode_sel = 4'b0000;
        press();
        check_val("zerohot_ignored", state, 1);
        mode_sel = 4'b0001;
        menu = 1'b1;
        step(1);
        menu = 1'b0;
        step(3);
        check_val("glitch_ignored", state, 1);

        mode_sel = 4'b0100;
        press();
        check_val("turbo_state", state, 2);
        check_val("turbo_lvl", lvl, 3);
        check_val("turbo_rem", remaining_sec, 2);
        press();
        check_val("turbo_press_state", state, 2);
        check_val("turbo_rem_7", remaining_sec, 1);
        step(1);
        check_val("turbo_done", done_pulse, 1);
        check_val("turbo_exp_rem", remaining_sec, 0);
`ifdef HOOD_TURBO_DOWNSHIFT_EN
        check_val("turbo_exp_state", state, 2);
        check_val("turbo_exp_lvl", lvl, 2);
        step(8);
        check_val("downshift_untimed", state, 2);
        press();
        check_val("downshift_exit", state, 1);
`else
        check_val("turbo_exp_state", state, 1);
        check_val("turbo_exp_lvl", lvl, 0);
`endif

        mode_sel = 4'b1000;
        press();
        step(3);
        power_on = 1'b0;
        step(1);
        check_val("pwr_drop_state", state, 0);
        check_val("pwr_drop_rem", remaining_sec, 0);
        power_on = 1'b1;
        step(1);
        check_val("pwr_restore", state, 1);

        press();
        step(11);
        power_on = 1'b0;
        step(1);
        check_val("coinc_state", state, 0);
        check_val("coinc_done", done_pulse, 0);
        power_on = 1'b1;
        step(1);

        mode_sel = 4'b0100;
        press();
        step(2);
        #2 reset = 1'b1;
        #1;
        check_val("async_rst_state", state, 0);
        check_val("async_rst_lvl", lvl, 0);
        check_val("async_rst_rem", remaining_sec, 0);
        check_val("async_rst_done", done_pulse, 0);
        step(1);
        reset = 1'b0;
        step(1);
        check_val("rst_restart", state, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
